// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by fetch_unit and its fetch buffer.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order fetch buffer: head is presented, skid absorbs
// the one fetch that can land while the head is held.
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  logic [31:0] push_instr,
  input  logic [31:0] push_pc4,
  output logic [31:0] head_instr,
  output logic [31:0] head_pc4,
  output logic        head_valid,
  output logic        skid_valid
);

  localparam entry_t EMPTY = {NOP_INSTR, 32'h0};

  entry_t head_r;
  entry_t skid_r;
  entry_t din;
  logic   head_v;
  logic   skid_v;

  assign din = {push_instr, push_pc4};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_r <= EMPTY;
      skid_r <= EMPTY;
      head_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (clear) begin
      head_r <= EMPTY;
      skid_r <= EMPTY;
      head_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (pop && skid_v) begin
      head_r <= skid_r;
      skid_r <= push ? din : EMPTY;
      skid_v <= push;
    end else if (pop) begin
      head_r <= push ? din : EMPTY;
      head_v <= push;
    end else if (push && !head_v) begin
      head_r <= din;
      head_v <= 1'b1;
    end else if (push) begin
      skid_r <= din;
      skid_v <= 1'b1;
    end
  end

  assign head_instr = head_r.instr;
  assign head_pc4   = head_r.pc4;
  assign head_valid = head_v;
  assign skid_valid = skid_v;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the req/ack imem port
// and feeds IF/ID from a two-entry buffer.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Stall_i,
  input  logic        Branch_i,
  input  logic [31:0] BranchTarget_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] PC_o,
  output logic [31:0] instruction_o,
  output logic        Valid_o,
  output logic        Flush_o
);

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc_r;
  logic [31:0] pc_nx;
  logic [31:0] tgt_r;
  logic [31:0] tgt_nx;
  logic [31:0] target;
  logic        push;
  logic        pop;
  logic        clear;
  logic        head_v;
  logic        skid_v;
  logic [1:0]  cnt_nx;

  assign target  = {BranchTarget_i[31:2], 2'b00};
  assign pop     = head_v & ~Stall_i & ~Branch_i;
  assign clear   = Branch_i;
  assign Flush_o = Branch_i;
  assign Valid_o = head_v;

  // Occupancy after this edge when an ack is accepted.
  assign cnt_nx = {1'b0, head_v} + {1'b0, skid_v}
                + 2'd1 - {1'b0, pop};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= FETCH;
      pc_r  <= RESET_PC;
      tgt_r <= RESET_PC;
    end else begin
      state <= state_nx;
      pc_r  <= pc_nx;
      tgt_r <= tgt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_r;
    tgt_nx   = tgt_r;
    push     = 1'b0;
    unique case (state)
      FETCH: begin
        unique case (1'b1)
          Branch_i && imem_ack_i: begin
            pc_nx = target;
          end
          Branch_i && !imem_ack_i: begin
            tgt_nx   = target;
            state_nx = DROP;
          end
          !Branch_i && imem_ack_i: begin
            push  = 1'b1;
            pc_nx = pc_r + PC_INC;
            if (cnt_nx == 2'd2) state_nx = HOLD;
          end
          default: ;
        endcase
      end
      HOLD: begin
        if (Branch_i) begin
          pc_nx    = target;
          state_nx = FETCH;
        end else if (pop) begin
          state_nx = FETCH;
        end
      end
      DROP: begin
        if (imem_ack_i) begin
          pc_nx    = Branch_i ? target : tgt_r;
          state_nx = FETCH;
        end else if (Branch_i) begin
          tgt_nx = target;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  always_comb begin
    imem_req_o  = rst_i && (state != HOLD);
    imem_addr_o = pc_r;
  end

  fetch_buf #(
    .NOP_INSTR(NOP_INSTR)
  ) u_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push       (push),
    .pop        (pop),
    .clear      (clear),
    .push_instr (imem_data_i),
    .push_pc4   (pc_r + PC_INC),
    .head_instr (instruction_o),
    .head_pc4   (PC_o),
    .head_valid (head_v),
    .skid_valid (skid_v)
  );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: the producer side of the IF/ID pipeline register.
- Owns the PC and drives a req/ack instruction-memory port.
- Buffers up to two fetched instructions and presents one instruction per cycle to IF/ID, honouring the same Stall_i the register sees.
- Redirects on a taken branch from ID and signals IF/ID to flush.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0000, instruction value driven when no valid instruction is presented

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
Stall_i  input  1  hazard-unit stall; IF/ID holds, so the presented instruction is not consumed
Branch_i  input  1  taken branch/jump resolved in ID
BranchTarget_i  input  32  redirect address; bits [1:0] ignored (forced 0)
imem_req_o  output  1  memory request
imem_addr_o  output  32  request address, word aligned
imem_ack_i  input  1  one-cycle completion pulse, data valid same cycle
imem_data_i  input  32  fetched instruction
PC_o  output  32  fetch address + 4 of presented instruction (to IF/ID PC_i)
instruction_o  output  32  presented instruction (to IF/ID instruction_i); NOP_INSTR when Valid_o=0
Valid_o  output  1  buffer entry 0 holds a live instruction
Flush_o  output  1  to IF/ID Flush_i; equals Branch_i registered 0 cycles (combinational pass-through)

Behaviour:
- Reset (rst_i=0, async):
  - pc_r=RESET_PC; state=FETCH; both buffer entries invalid.
  - Outputs: PC_o=0, instruction_o=NOP_INSTR, Valid_o=0.
  - imem_req_o=0 while rst_i=0.
- Consume event: posedge with Valid_o=1, Stall_i=0, Branch_i=0.
- Buffer: 2 entries (head = presented, skid). Each entry = {instr, pc+4}. Outputs are registered from head.
- Memory rules:
  - imem_addr_o is stable and imem_req_o stays high from request start until ack.
  - At most one outstanding request; a request is never withdrawn.
- States:
  - FETCH (req=1, addr=pc_r): request outstanding or issuing.
  - HOLD (req=0): both entries full, waiting for a consume.
  - DROP (req=1, addr=pc_r): outstanding request belongs to a squashed path; its data is discarded.
- FETCH transitions:
  - ack & Branch_i: discard data; clear buffer; pc_r=target; stay FETCH. New address is issued next cycle.
  - !ack & Branch_i: clear buffer; tgt_r=target; go DROP.
  - ack & !Branch_i: write data to head if head is free or consumed this cycle, else to skid. pc_r+=4.
    - Go HOLD if both entries are full after the update; else stay FETCH.
  - Simultaneous ack and consume with skid full: skid->head, data->skid.
- HOLD transitions:
  - Branch_i: clear buffer; pc_r=target; go FETCH.
  - Consume: skid->head; go FETCH.
- DROP transitions:
  - Branch_i: tgt_r=newest target.
  - ack: discard data; pc_r=tgt_r (or BranchTarget_i if Branch_i same cycle); go FETCH.
- Priority: Branch_i > Stall_i.
  - A branch clears the buffer even when stalled (IF/ID is flushed or held by hazard policy).
- Latency and throughput:
  - A 1-cycle-ack memory gives 1 instruction/cycle.
  - First instruction after reset: Valid_o=1 one cycle after the first ack.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Reset mid-request: ack arriving during or after reset for the old request is ignored. No state exists outside FETCH after reset.

Decomposition:
- Shared package: state enum {FETCH, HOLD, DROP}, NOP_INSTR constant, PC increment constant 4.
- One sub-module, fetch_buf: 2-entry in-order buffer with push/pop/clear, head outputs registered.
- PC/FSM logic stays in fetch_unit.

Test Plan:
- Reset with 1-cycle-ack memory, no stall -> addresses 0,4,8,... on consecutive cycles; Valid_o=1 from the cycle after the first ack; PC_o=4,8,12 tracking instruction_o.
- Stall_i held 4 cycles mid-stream -> one further ack fills skid, then imem_req_o=0 (HOLD). instruction_o/PC_o frozen. After release, skid instruction presented next cycle; no loss or duplication.
- Branch_i=1, target 32'h0000_0103, with no request outstanding -> Flush_o=1 same cycle; buffer cleared; next imem_addr_o=32'h100.
- 3-cycle-latency memory, Branch_i to 32'h200 one cycle after request to 32'h40 -> imem_addr_o stays 32'h40 until ack. That data is never presented; next request is 32'h200.
- Two branches during DROP (targets 32'h300 then 32'h400) -> after ack, fetch resumes at 32'h400.
- Fetch at 32'hFFFF_FFFC -> PC_o=0, next request address 0; rst_i asserted during outstanding request -> req=0 immediately, Valid_o=0, restart at RESET_PC.
